// File: rtl/iopmp_check_arbiter_if.sv
// Access-type package and the request/checker bundle shared by the arbiter and its neighbours.
// slave = arbiter view, master = request handlers plus checker view.
package iopmp_check_arbiter_pkg;
  typedef enum logic {
    IOPMP_ACC_READ  = 1'b0,
    IOPMP_ACC_WRITE = 1'b1
  } iopmp_req_e;
endpackage

interface iopmp_check_arbiter_if #(
  parameter int N         = 2,
  parameter int AddrWidth = 34,
  parameter int RridWidth = 1
);
  logic [N-1:0]                              req_valid_i;
  logic [N-1:0][AddrWidth-1:0]               req_addr_i;
  iopmp_check_arbiter_pkg::iopmp_req_e [N-1:0] req_access_i;
  logic [N-1:0]                              rsp_valid_o;
  logic [N-1:0]                              rsp_denied_o;
  logic [N-1:0]                              rsp_err_o;
  logic                                      chk_valid_o;
  logic [AddrWidth-1:0]                      chk_addr_o;
  iopmp_check_arbiter_pkg::iopmp_req_e       chk_access_o;
  logic [RridWidth-1:0]                      chk_rrid_o;
  logic                                      chk_done_i;
  logic                                      chk_denied_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_access_i, chk_done_i, chk_denied_i,
    output rsp_valid_o, rsp_denied_o, rsp_err_o, chk_valid_o, chk_addr_o, chk_access_o, chk_rrid_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_access_i, chk_done_i, chk_denied_i,
    input  rsp_valid_o, rsp_denied_o, rsp_err_o, chk_valid_o, chk_addr_o, chk_access_o, chk_rrid_o
  );
endinterface

// File: rtl/iopmp_check_arbiter.sv
// Round-robin arbiter sharing one IOPMP checker among IOPMPNumChan channels, one check in flight.
// Optional WAIT timeout with forced deny enabled by defining IOPMP_CHK_TIMEOUT_EN.
module iopmp_check_arbiter
  import iopmp_check_arbiter_pkg::*;
#(
  parameter int IOPMPNumChan  = 2,
  parameter int AddrWidth     = 34,
  parameter int RridWidth     = (IOPMPNumChan > 1) ? $clog2(IOPMPNumChan) : 1,
  parameter int TimeoutCycles = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  iopmp_check_arbiter_if.slave  bus,
  output logic                  busy_o
);

  localparam int IdxW = (IOPMPNumChan > 1) ? $clog2(IOPMPNumChan) : 1;
  localparam logic [IdxW:0]   NumChanW = (IdxW + 1)'(IOPMPNumChan);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(IOPMPNumChan - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]      grant_q, grant_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  iopmp_req_e           access_q, access_d;
  logic                 denied_q, denied_d;

  logic                 pick_found;
  logic [IdxW-1:0]      pick_idx;
  logic [IdxW:0]        cand_sum;
  logic [IdxW-1:0]      cand;

`ifdef IOPMP_CHK_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TimeoutCycles == 0);
`endif

  // Walk from the highest offset down so the channel closest to rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int off = IOPMPNumChan - 1; off >= 0; off--) begin
      cand_sum = {1'b0, rr_ptr_q} + (IdxW + 1)'(off);
      cand     = (cand_sum >= NumChanW) ? IdxW'(cand_sum - NumChanW) : IdxW'(cand_sum);
      if (bus.req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    access_d = access_q;
    denied_d = denied_q;
`ifdef IOPMP_CHK_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d  = pick_idx;
          addr_d   = bus.req_addr_i[pick_idx];
          access_d = bus.req_access_i[pick_idx];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
`ifdef IOPMP_CHK_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.chk_done_i) begin
          denied_d = bus.chk_denied_i;
`ifdef IOPMP_CHK_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = RESP;
        end
`ifdef IOPMP_CHK_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          denied_d = 1'b1;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        rr_ptr_d = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      access_q <= IOPMP_ACC_READ;
      denied_q <= 1'b0;
`ifdef IOPMP_CHK_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      access_q <= access_d;
      denied_q <= denied_d;
`ifdef IOPMP_CHK_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign bus.chk_valid_o  = (state_q == ISSUE);
  assign bus.chk_addr_o   = addr_q;
  assign bus.chk_access_o = access_q;
  assign bus.chk_rrid_o   = RridWidth'(grant_q);
  assign busy_o           = (state_q != IDLE);

  for (genvar gi = 0; gi < IOPMPNumChan; gi++) begin : g_rsp
    logic sel;
    assign sel                   = (state_q == RESP) && (grant_q == IdxW'(gi));
    assign bus.rsp_valid_o[gi]   = sel;
    assign bus.rsp_denied_o[gi]  = sel & denied_q;
`ifdef IOPMP_CHK_TIMEOUT_EN
    assign bus.rsp_err_o[gi]     = sel & err_q;
`else
    assign bus.rsp_err_o[gi]     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_iopmp_check_arbiter.sv
// Self-checking bench for iopmp_check_arbiter: vector table, contention, snapshot, spurious done,
// reset mid-check and WAIT timeout, with a response scoreboard.
module tb_iopmp_check_arbiter;
  import iopmp_check_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int AW = 34;

  logic clk = 1'b0;
  logic rst;
  logic busy_o;

  iopmp_check_arbiter_if #(.N(N), .AddrWidth(AW), .RridWidth(1)) bus ();

  iopmp_check_arbiter #(
    .IOPMPNumChan (N),
    .AddrWidth    (AW),
    .RridWidth    (1),
    .TimeoutCycles(16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic       denied;
    logic       err;
  } exp_t;

  typedef struct {
    int             ch;
    logic [AW-1:0]  addr;
    iopmp_req_e     acc;
    logic           denied;
    int             dly;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs [6];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < N; c++) begin
        if (bus.rsp_valid_o[c]) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid on ch%0d, expected none at %0t", c, $time);
          end else begin
            mon_e = sb_q.pop_front();
            chk("sb_rsp_ch", 64'(c), 64'(mon_e.ch));
            chk("sb_rsp_denied", 64'(bus.rsp_denied_o[c]), 64'(mon_e.denied));
            chk("sb_rsp_err", 64'(bus.rsp_err_o[c]), 64'(mon_e.err));
          end
        end
      end
    end
  end

  // Entry and exit: FSM in IDLE, no requests, just after a clock edge.
  task automatic do_check(input vec_t v);
    bus.req_valid_i[v.ch]  = 1'b1;
    bus.req_addr_i[v.ch]   = v.addr;
    bus.req_access_i[v.ch] = v.acc;
    sb_q.push_back('{v.ch, v.denied, 1'b0});
    step();
    chk("vec_chk_valid", 64'(bus.chk_valid_o), 64'(1));
    chk("vec_chk_rrid", 64'(bus.chk_rrid_o), 64'(v.ch));
    chk("vec_chk_addr", 64'(bus.chk_addr_o), 64'(v.addr));
    chk("vec_chk_access", 64'(bus.chk_access_o), 64'(v.acc));
    step();
    chk("vec_chk_valid_pulse", 64'(bus.chk_valid_o), 64'(0));
    for (int k = 0; k < v.dly; k++) step();
    bus.chk_done_i   = 1'b1;
    bus.chk_denied_i = v.denied;
    step();
    bus.chk_done_i   = 1'b0;
    bus.chk_denied_i = 1'b0;
    chk("vec_rsp_valid", 64'(bus.rsp_valid_o), 64'(1) << v.ch);
    bus.req_valid_i[v.ch] = 1'b0;
    step();
    chk("vec_rsp_one_cycle", 64'(bus.rsp_valid_o), 64'(0));
    chk("vec_idle", 64'(busy_o), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   g;
    logic den;

    vecs[0] = '{0, 34'h0_0000_1000, IOPMP_ACC_READ,  1'b0, 0};
    vecs[1] = '{1, 34'h2_0000_0004, IOPMP_ACC_WRITE, 1'b1, 2};
    vecs[2] = '{0, 34'h3_FFFF_FFFF, IOPMP_ACC_WRITE, 1'b0, 5};
    vecs[3] = '{1, 34'h0_0000_0000, IOPMP_ACC_READ,  1'b1, 1};
    vecs[4] = '{1, 34'h0_0000_1234, IOPMP_ACC_READ,  1'b0, 0};
    vecs[5] = '{0, 34'h2_AAAA_5555, IOPMP_ACC_WRITE, 1'b1, 3};

    rst              = 1'b1;
    bus.req_valid_i  = '0;
    bus.req_addr_i   = '0;
    bus.req_access_i = {N{IOPMP_ACC_READ}};
    bus.chk_done_i   = 1'b0;
    bus.chk_denied_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    chk("reset_chk_valid", 64'(bus.chk_valid_o), 64'(0));
    chk("reset_busy", 64'(busy_o), 64'(0));
    chk("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    chk("reset_chk_addr", 64'(bus.chk_addr_o), 64'(0));
    chk("reset_chk_access", 64'(bus.chk_access_o), 64'(IOPMP_ACC_READ));
    chk("reset_chk_rrid", 64'(bus.chk_rrid_o), 64'(0));

    // Contention: both channels held valid, grants must alternate from ch0.
    bus.req_valid_i   = 2'b11;
    bus.req_addr_i[0] = 34'h100;
    bus.req_addr_i[1] = 34'h200;
    for (int r = 0; r < 4; r++) begin
      g   = r % 2;
      den = (r == 1 || r == 2);
      sb_q.push_back('{g, den, 1'b0});
      step();
      chk("cont_chk_valid", 64'(bus.chk_valid_o), 64'(1));
      chk("cont_rrid", 64'(bus.chk_rrid_o), 64'(g));
      chk("cont_addr", 64'(bus.chk_addr_o), (g == 0) ? 64'h100 : 64'h200);
      step();
      bus.chk_done_i   = 1'b1;
      bus.chk_denied_i = den;
      step();
      bus.chk_done_i   = 1'b0;
      bus.chk_denied_i = 1'b0;
      chk("cont_rsp_own_ch", 64'(bus.rsp_valid_o), 64'(1) << g);
      step();
    end
    bus.req_valid_i = '0;
    step();
    chk("cont_idle", 64'(busy_o), 64'(0));

    for (int i = 0; i < 6; i++) do_check(vecs[i]);

    // Snapshot: address change during WAIT must not reach the checker.
    bus.req_valid_i[1]  = 1'b1;
    bus.req_addr_i[1]   = 34'h2000;
    bus.req_access_i[1] = IOPMP_ACC_WRITE;
    sb_q.push_back('{1, 1'b1, 1'b0});
    step();
    chk("snap_issue_addr", 64'(bus.chk_addr_o), 64'h2000);
    step();
    bus.req_addr_i[1] = 34'h3000;
    step();
    chk("snap_wait_addr", 64'(bus.chk_addr_o), 64'h2000);
    chk("snap_wait_access", 64'(bus.chk_access_o), 64'(IOPMP_ACC_WRITE));
    chk("snap_wait_no_rsp", 64'(bus.rsp_valid_o), 64'(0));
    bus.chk_done_i   = 1'b1;
    bus.chk_denied_i = 1'b1;
    step();
    bus.chk_done_i   = 1'b0;
    bus.chk_denied_i = 1'b0;
    chk("snap_rsp_valid", 64'(bus.rsp_valid_o), 64'b10);
    chk("snap_rsp_denied", 64'(bus.rsp_denied_o), 64'b10);
    chk("snap_resp_addr", 64'(bus.chk_addr_o), 64'h2000);
    bus.req_valid_i[1] = 1'b0;
    step();
    chk("snap_idle_keeps_addr", 64'(bus.chk_addr_o), 64'h2000);

    // Spurious done in IDLE and ISSUE must be ignored.
    bus.chk_done_i   = 1'b1;
    bus.chk_denied_i = 1'b1;
    step();
    bus.chk_done_i   = 1'b0;
    bus.chk_denied_i = 1'b0;
    chk("spur_idle_busy", 64'(busy_o), 64'(0));
    chk("spur_idle_rsp", 64'(bus.rsp_valid_o), 64'(0));
    bus.req_valid_i[0]  = 1'b1;
    bus.req_addr_i[0]   = 34'h40;
    bus.req_access_i[0] = IOPMP_ACC_READ;
    sb_q.push_back('{0, 1'b0, 1'b0});
    step();
    chk("spur_issue", 64'(bus.chk_valid_o), 64'(1));
    bus.chk_done_i   = 1'b1;
    bus.chk_denied_i = 1'b1;
    step();
    bus.chk_done_i   = 1'b0;
    bus.chk_denied_i = 1'b0;
    step();
    chk("spur_still_wait_busy", 64'(busy_o), 64'(1));
    chk("spur_still_wait_rsp", 64'(bus.rsp_valid_o), 64'(0));
    bus.chk_done_i = 1'b1;
    step();
    bus.chk_done_i = 1'b0;
    chk("spur_rsp_valid", 64'(bus.rsp_valid_o), 64'b01);
    chk("spur_rsp_denied", 64'(bus.rsp_denied_o), 64'(0));
    bus.req_valid_i[0] = 1'b0;
    step();

    // Reset mid-check: rr_ptr is 1 here, so after reset ch0 must win again.
    bus.req_valid_i[1] = 1'b1;
    step();
    step();
    rst                = 1'b1;
    bus.req_valid_i[1] = 1'b0;
    step();
    rst = 1'b0;
    chk("rstmid_busy", 64'(busy_o), 64'(0));
    chk("rstmid_chk_valid", 64'(bus.chk_valid_o), 64'(0));
    step();
    bus.chk_done_i = 1'b1;
    step();
    bus.chk_done_i = 1'b0;
    chk("rstmid_late_done_rsp", 64'(bus.rsp_valid_o), 64'(0));
    chk("rstmid_late_done_busy", 64'(busy_o), 64'(0));
    bus.req_valid_i = 2'b11;
    sb_q.push_back('{0, 1'b0, 1'b0});
    step();
    chk("rstmid_next_grant", 64'(bus.chk_rrid_o), 64'(0));
    step();
    bus.chk_done_i = 1'b1;
    step();
    bus.chk_done_i = 1'b0;
    chk("rstmid_rsp", 64'(bus.rsp_valid_o), 64'b01);
    bus.req_valid_i = '0;
    step();

    // Timeout: checker never answers.
    bus.req_valid_i[1] = 1'b1;
`ifdef IOPMP_CHK_TIMEOUT_EN
    sb_q.push_back('{1, 1'b1, 1'b1});
`endif
    step();
    chk("tmo_issue", 64'(bus.chk_valid_o), 64'(1));
    seen = 1'b0;
`ifdef IOPMP_CHK_TIMEOUT_EN
    for (int k = 2; k <= 17; k++) begin
      step();
      if (bus.rsp_valid_o != '0) seen = 1'b1;
    end
    chk("tmo_early_rsp", 64'(seen), 64'(0));
    step();
    chk("tmo_rsp_valid", 64'(bus.rsp_valid_o), 64'b10);
    chk("tmo_rsp_denied", 64'(bus.rsp_denied_o), 64'b10);
    chk("tmo_rsp_err", 64'(bus.rsp_err_o), 64'b10);
    bus.req_valid_i[1] = 1'b0;
    step();
    chk("tmo_idle", 64'(busy_o), 64'(0));
`else
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.rsp_valid_o != '0 || busy_o != 1'b1) seen = 1'b1;
    end
    chk("notmo_waits_forever", 64'(seen), 64'(0));
    rst                = 1'b1;
    bus.req_valid_i[1] = 1'b0;
    step();
    rst = 1'b0;
    chk("notmo_reset_idle", 64'(busy_o), 64'(0));
`endif
    step();
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
